// File: rtl/fp_div.sv
// Multi-cycle IEEE-754 divider: unpack, restoring shift-subtract divide, round, pack.
// Define FP_DIV_RNE_EN for round-to-nearest-even; default build truncates toward zero.
module fp_div #(
  parameter int PRECISION = 32,
  parameter int EXPONENT  = 8,
  parameter int FRACTION  = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PRECISION-1:0] a_operand,
  input  logic [PRECISION-1:0] b_operand,
  output logic                 busy,
  output logic                 done,
  output logic [PRECISION-1:0] result
);

  localparam int EW = EXPONENT + 2;
  localparam int MW = FRACTION + 1;
  localparam int RW = FRACTION + 2;
  localparam int QW = FRACTION + 3;
  localparam int CW = $clog2(QW) + 1;

  localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXPONENT - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXPONENT) - 1);
  localparam logic [CW-1:0]        LAST_IT = CW'(QW - 1);

  localparam logic [1:0] CLS_NORM = 2'd0;
  localparam logic [1:0] CLS_NAN  = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_ZERO = 2'd3;

`ifdef FP_DIV_RNE_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    DIVIDE = 3'd2,
    ROUND  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state, state_next;

  logic [PRECISION-1:0]  a_reg, b_reg;
  logic                  sign;
  logic signed [EW-1:0]  exp;
  logic [MW-1:0]         mb;
  logic [RW-1:0]         rem;
  logic [QW-1:0]         quo;
  logic                  sticky;
  logic [1:0]            cls;
  logic [CW-1:0]         count;

  // Operand field decode and special-case classification
  logic [EXPONENT-1:0] ea, eb;
  logic [FRACTION-1:0] fa, fb;
  logic a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
  logic [1:0] cls_in;

  always_comb begin
    ea     = a_reg[PRECISION-2 -: EXPONENT];
    eb     = b_reg[PRECISION-2 -: EXPONENT];
    fa     = a_reg[FRACTION-1:0];
    fb     = b_reg[FRACTION-1:0];
    // Denormals have a zero exponent field and are flushed to zero here.
    a_zero = (ea == {EXPONENT{1'b0}});
    b_zero = (eb == {EXPONENT{1'b0}});
    a_nan  = (&ea) & (|fa);
    b_nan  = (&eb) & (|fb);
    a_inf  = (&ea) & ~(|fa);
    b_inf  = (&eb) & ~(|fb);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      cls_in = CLS_NAN;
    end else if ((b_zero && !a_zero) || (a_inf && !b_inf)) begin
      cls_in = CLS_INF;
    end else if ((a_zero && !b_zero) || (b_inf && !a_inf)) begin
      cls_in = CLS_ZERO;
    end else begin
      cls_in = CLS_NORM;
    end
  end

  // One restoring shift-subtract step
  logic [RW:0]   diff;
  logic          ge;
  logic [RW-1:0] rem_next;

  always_comb begin
    diff     = {1'b0, rem} - {2'b00, mb};
    ge       = ~diff[RW];
    if (ge) begin
      rem_next = diff[RW-1:0];
    end else begin
      rem_next = rem;
    end
  end

  // Normalize, round, detect exponent range and pack the final word
  logic [QW-1:0]         norm_q;
  logic signed [EW-1:0]  exp_n, exp_r;
  logic                  round_up;
  logic [MW:0]           mant_sum;
  logic [FRACTION-1:0]   frac;
  logic [PRECISION-1:0]  packed_res;

  always_comb begin
    if (quo[QW-1]) begin
      norm_q = quo;
      exp_n  = exp;
    end else begin
      norm_q = {quo[QW-2:0], 1'b0};
      exp_n  = exp - EW'(1);
    end
    // Guard is norm_q[1]; anything below it, or left in the remainder, is sticky.
    round_up = RNE & norm_q[1] & (norm_q[0] | sticky | norm_q[2]);
    mant_sum = {1'b0, norm_q[QW-1:2]} + {{MW{1'b0}}, round_up};
    if (mant_sum[MW]) begin
      frac  = mant_sum[FRACTION:1];
      exp_r = exp_n + EW'(1);
    end else begin
      frac  = mant_sum[FRACTION-1:0];
      exp_r = exp_n;
    end
    case (cls)
      CLS_NAN:  packed_res = {1'b0, {EXPONENT{1'b1}}, 1'b1, {(FRACTION-1){1'b0}}};
      CLS_INF:  packed_res = {sign, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
      CLS_ZERO: packed_res = {sign, {(PRECISION-1){1'b0}}};
      default: begin
        if (exp_r >= EXP_MAX) begin
          packed_res = {sign, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
        end else if (exp_r <= EW'(0)) begin
          packed_res = {sign, {(PRECISION-1){1'b0}}};
        end else begin
          packed_res = {sign, exp_r[EXPONENT-1:0], frac};
        end
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = UNPACK;
        end else begin
          state_next = IDLE;
        end
      end
      UNPACK: state_next = DIVIDE;
      DIVIDE: begin
        if (count == LAST_IT) begin
          state_next = ROUND;
        end else begin
          state_next = DIVIDE;
        end
      end
      ROUND:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg  <= {PRECISION{1'b0}};
      b_reg  <= {PRECISION{1'b0}};
      sign   <= 1'b0;
      exp    <= {EW{1'b0}};
      mb     <= {MW{1'b0}};
      rem    <= {RW{1'b0}};
      quo    <= {QW{1'b0}};
      sticky <= 1'b0;
      cls    <= CLS_NORM;
      count  <= {CW{1'b0}};
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= {PRECISION{1'b0}};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a_operand;
            b_reg <= b_operand;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        UNPACK: begin
          sign   <= a_reg[PRECISION-1] ^ b_reg[PRECISION-1];
          exp    <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
          mb     <= {1'b1, fb};
          rem    <= {1'b0, 1'b1, fa};
          quo    <= {QW{1'b0}};
          sticky <= 1'b0;
          cls    <= cls_in;
          count  <= {CW{1'b0}};
        end
        DIVIDE: begin
          rem   <= {rem_next[RW-2:0], 1'b0};
          quo   <= {quo[QW-2:0], ge};
          count <= count + CW'(1);
          if (count == LAST_IT) begin
            sticky <= (rem_next != {RW{1'b0}});
          end else begin
            sticky <= sticky;
          end
        end
        ROUND: begin
          result <= packed_res;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        DONE: begin
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fp_div.md
FP_DIV -- requirements
Module: fp_div

Interface
REQ-001 The module SHALL take parameter PRECISION, default 32, the total IEEE-754 word width.
REQ-002 The module SHALL take parameter EXPONENT, default 8, the exponent field width.
REQ-003 The module SHALL take parameter FRACTION, default 23, the fraction field width, with PRECISION = 1+EXPONENT+FRACTION.
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit, an asynchronous active-high reset.
REQ-006 The module SHALL have port start, input, 1 bit, the request to begin a division.
REQ-007 The module SHALL have port a_operand, input, PRECISION bits, the dividend.
REQ-008 The module SHALL have port b_operand, input, PRECISION bits, the divisor.
REQ-009 The module SHALL have port busy, output, 1 bit, high while a division is in progress.
REQ-010 The module SHALL have port done, output, 1 bit, a one-cycle pulse marking result valid.
REQ-011 The module SHALL have port result, output, PRECISION bits, the quotient a/b, held until the next done pulse.

Function
REQ-012 The FSM SHALL use the state sequence IDLE -> UNPACK -> DIVIDE -> ROUND -> DONE -> IDLE.
REQ-013 In IDLE, start=1 at a rising edge SHALL capture both operands and enter UNPACK; busy goes high at that same edge.
REQ-014 start SHALL be ignored while busy=1, and the operands captured at acceptance SHALL remain in use.
REQ-015 UNPACK SHALL take 1 cycle: sign = sa XOR sb, exponent = ea - eb + bias(2^(EXPONENT-1)-1), hidden bit restored, special cases classified.
REQ-016 DIVIDE SHALL be a restoring shift-subtract loop of exactly FRACTION+3 cycles, one quotient bit per cycle, with iteration counter 0..FRACTION+2 and a sticky bit set from a nonzero final remainder.
REQ-017 ROUND SHALL take 1 cycle: if quotient MSB=0, shift left 1 and decrement exponent; round; renormalize on mantissa carry-out.
REQ-018 done SHALL be high for exactly one cycle in DONE with result valid; busy SHALL drop at the same edge done rises; start is accepted again in the following IDLE cycle.
REQ-019 Latency SHALL be fixed at FRACTION+6 rising edges from the accepting edge to done high (29 for the defaults), including special cases.
REQ-020 A NaN on either input, 0/0, or inf/inf SHALL produce canonical NaN: sign 0, exponent all ones, fraction MSB 1, rest 0 (7FC00000).
REQ-021 x/0 with x nonzero, inf/finite, and exponent overflow (biased >= 2^EXPONENT-1) SHALL produce signed infinity.
REQ-022 0/x with x nonzero, finite/inf, and exponent underflow (biased <= 0) SHALL produce signed zero; denormal inputs SHALL be flushed to zero.
REQ-023 The internal exponent SHALL be held in EXPONENT+2 signed bits so that overflow and underflow are detected without wrap-around.

Reset
REQ-024 Asserting reset SHALL immediately force state=IDLE, busy=0, done=0, result=0, and counter=0.
REQ-025 Reset asserted mid-operation SHALL abort the division, and no done pulse SHALL follow for it.
REQ-026 After reset deasserts, a start at the first rising edge SHALL be accepted.

Configuration
REQ-027 With macro FP_DIV_RNE_EN defined, ROUND SHALL apply round-to-nearest-even using the guard and sticky bits.
REQ-028 Without FP_DIV_RNE_EN, ROUND SHALL truncate toward zero, with guard and sticky discarded; latency SHALL be identical in both builds.

Verification
REQ-029 The bench SHALL cover 3FC00000 / 3F000000 (1.5/0.5) -> result 40400000, with done exactly 29 edges after start.
REQ-030 The bench SHALL cover C0800000 / 40000000 (-4/2) -> result C0000000; a start pulsed while busy -> ignored and the result unchanged.
REQ-031 The bench SHALL cover 3F800000 / 40400000 (1/3) -> 3EAAAAAB with FP_DIV_RNE_EN and 3EAAAAAA without.
REQ-032 The bench SHALL cover 3F800000 / 00000000 -> 7F800000; 00000000 / 00000000 -> 7FC00000; 7F000000 / 3E800000 -> 7F800000.
REQ-033 The bench SHALL cover 00800000 / 40000000 (denormal result) -> 00000000.
REQ-034 The bench SHALL cover reset pulsed 10 cycles after start -> busy=0, done=0, result=00000000 immediately, and no done pulse within the next 40 cycles.
